// File: rtl/sharedreg_arb_pkg.sv
// Shared types and helpers for the shared-register arbiter.
package sharedreg_arb_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Lock counter must be able to hold the value MAXLOCK itself.
   function automatic int cnt_width(input int maxlock);
      return $clog2(maxlock + 1);
   endfunction

endpackage

// File: rtl/flopenr.sv
// Standard enable flop with synchronous active-high reset.
module flopenr #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Reset has priority over the enable.
   always_ff @(posedge clk) begin
      if (reset)   q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/sharedreg_arb_rrpick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module sharedreg_arb_rrpick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] onehot,
   output logic [IW-1:0]   idx,
   output logic            any
);

   // Walk NREQ positions starting at ptr; the first hit wins.
   always_comb begin
      int j;
      j      = 0;
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(ptr) + k) % NREQ;
         if (!any && req[j]) begin
            any       = 1'b1;
            onehot[j] = 1'b1;
            idx       = IW'(j);
         end
      end
   end

endmodule

// File: rtl/sharedreg_arb.sv
// Round-robin arbiter with bounded lock for one shared enable register.
module sharedreg_arb
   import sharedreg_arb_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int NREQ    = 4,
   parameter int MAXLOCK = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         Req,
   input  logic [NREQ-1:0]         Lock,
   input  logic [NREQ*WIDTH-1:0]   WData,
   output logic [NREQ-1:0]         Grant,
   output logic [$clog2(NREQ)-1:0] GrantIdx,
   output logic [WIDTH-1:0]        Q,
   output logic                    QWritten,
   output logic                    LockTimeout
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = cnt_width(MAXLOCK);

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   owner;
   logic [CW-1:0]   cnt;

   logic [NREQ-1:0] pick_oh;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;

   logic            own_req;
   logic            own_lock;
   logic            wr;
   logic [WIDTH-1:0] wsel;
   logic [IW-1:0]   ptr_nxt;
   logic [CW-1:0]   cnt_nxt;

   sharedreg_arb_rrpick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req    (Req),
      .ptr    (ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign own_req  = Req[owner];
   assign own_lock = Lock[owner];
   assign ptr_nxt  = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
   assign cnt_nxt  = cnt + 1'b1;

   // Grant is combinational; forced to zero in reset so no write can sneak in.
   always_comb begin
      Grant    = '0;
      GrantIdx = '0;
      if (!reset) begin
         if (state == ARB) begin
            Grant    = pick_oh;
            GrantIdx = pick_idx;
         end else if (own_req) begin
            Grant[owner] = 1'b1;
            GrantIdx     = owner;
         end
      end
   end

   assign wr   = |Grant;
   assign wsel = WData[int'(GrantIdx)*WIDTH +: WIDTH];

   flopenr #(.WIDTH(WIDTH)) u_q (
      .clk   (clk),
      .reset (reset),
      .en    (wr),
      .d     (wsel),
      .q     (Q)
   );

   // Arbitration FSM: pointer, owner, lock counter and status pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ARB;
         ptr         <= '0;
         owner       <= '0;
         cnt         <= '0;
         QWritten    <= 1'b0;
         LockTimeout <= 1'b0;
      end else begin
         QWritten    <= wr;
         LockTimeout <= 1'b0;
         case (state)
            ARB: begin
               if (pick_any) begin
                  ptr <= ptr_nxt;
                  if (Lock[pick_idx]) begin
                     state <= HOLD;
                     owner <= pick_idx;
                     cnt   <= CW'(1);
                  end
               end
            end
            HOLD: begin
               // Pointer stays put: it already points past the owner.
               if (!own_req || !own_lock) begin
                  state <= ARB;
                  cnt   <= '0;
               end else if (cnt_nxt == CW'(MAXLOCK)) begin
                  state       <= ARB;
                  cnt         <= '0;
                  LockTimeout <= 1'b1;
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_sharedreg_arb.sv
// Directed scoreboard bench for sharedreg_arb (NREQ=4, WIDTH=8, MAXLOCK=8).
module tb_sharedreg_arb;

   localparam int WIDTH   = 8;
   localparam int NREQ    = 4;
   localparam int MAXLOCK = 8;

   typedef struct {
      logic [NREQ-1:0]  g;
      logic [1:0]       idx;
      logic [WIDTH-1:0] q;
      logic             qw;
      logic             lto;
   } rec_t;

   logic                  clk;
   logic                  reset;
   logic [NREQ-1:0]       Req;
   logic [NREQ-1:0]       Lock;
   logic [NREQ*WIDTH-1:0] WData;
   logic [NREQ-1:0]       Grant;
   logic [1:0]            GrantIdx;
   logic [WIDTH-1:0]      Q;
   logic                  QWritten;
   logic                  LockTimeout;

   int checks = 0;
   int errors = 0;

   rec_t             cyc_q[$];
   logic [WIDTH-1:0] wr_q[$];
   logic [WIDTH-1:0] dat[NREQ];
   logic [WIDTH-1:0] eq;
   logic             eqw;

   sharedreg_arb #(
      .WIDTH   (WIDTH),
      .NREQ    (NREQ),
      .MAXLOCK (MAXLOCK)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .Req         (Req),
      .Lock        (Lock),
      .WData       (WData),
      .Grant       (Grant),
      .GrantIdx    (GrantIdx),
      .Q           (Q),
      .QWritten    (QWritten),
      .LockTimeout (LockTimeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] oh2idx(input logic [NREQ-1:0] oh);
      logic [1:0] r;
      r = '0;
      for (int i = 0; i < NREQ; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; eg is the hand-computed grant, elto the expected pulse.
   task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic [NREQ-1:0] lk,
                       input logic [NREQ-1:0] eg, input logic elto);
      rec_t e;
      @(posedge clk);
      #1;
      reset = r;
      Req   = rq;
      Lock  = lk;
      for (int i = 0; i < NREQ; i++) WData[i*WIDTH +: WIDTH] = dat[i];
      e.g   = eg;
      e.idx = oh2idx(eg);
      e.q   = eq;
      e.qw  = eqw;
      e.lto = elto;
      cyc_q.push_back(e);
      if (r) begin
         eq  = '0;
         eqw = 1'b0;
      end else if (eg != '0) begin
         eq  = dat[oh2idx(eg)];
         eqw = 1'b1;
         wr_q.push_back(dat[oh2idx(eg)]);
      end else begin
         eqw = 1'b0;
      end
   endtask

   // Monitor: per-cycle outputs, plus write data whenever QWritten is presented.
   always @(negedge clk) begin
      rec_t e;
      if (cyc_q.size() > 0) begin
         e = cyc_q.pop_front();
         chk("grant",        32'(Grant),       32'(e.g));
         chk("grant_idx",    32'(GrantIdx),    32'(e.idx));
         chk("q",            32'(Q),           32'(e.q));
         chk("qwritten",     32'(QWritten),    32'(e.qw));
         chk("lock_timeout", 32'(LockTimeout), 32'(e.lto));
      end
      if (QWritten === 1'b1) begin
         if (wr_q.size() == 0) chk("unexpected_write", 32'(1), 32'(0));
         else                  chk("write_data", 32'(Q), 32'(wr_q.pop_front()));
      end
   end

   initial begin
      reset = 1'b1;
      Req   = '0;
      Lock  = '0;
      WData = '0;
      eq    = '0;
      eqw   = 1'b0;
      dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'h33; dat[3] = 8'h44;
      repeat (2) @(posedge clk);

      // Fairness: all requesting, no lock -> 0,1,2,3,0,1,2,3 (first record checks reset state)
      for (int i = 0; i < 8; i++) step(0, 4'b1111, 4'b0000, 4'b0001 << (i % 4), 0);

      // Wrap and skip: drive pointer to 3, then 0101 -> 0, then 2; idle holds Q
      step(0, 4'b0100, 4'b0000, 4'b0100, 0);
      step(0, 4'b0101, 4'b0000, 4'b0001, 0);
      step(0, 4'b0101, 4'b0000, 4'b0100, 0);
      step(0, 4'b0000, 4'b0000, 4'b0000, 0);
      step(0, 4'b0000, 4'b0000, 4'b0000, 0);

      // Normal lock by requester 1 while 2 waits (pointer is 3)
      for (int i = 0; i < 3; i++) step(0, 4'b0110, 4'b0010, 4'b0010, 0);
      step(0, 4'b0110, 4'b0000, 4'b0010, 0);
      step(0, 4'b0110, 4'b0000, 4'b0100, 0);
      step(0, 4'b0000, 4'b0000, 4'b0000, 0);

      // Forced release: requester 0 locks for MAXLOCK grants, 3 waits
      dat[0] = 8'h5A; dat[1] = 8'hC3; dat[2] = 8'h96; dat[3] = 8'h0F;
      step(0, 4'b1000, 4'b0000, 4'b1000, 0);
      for (int i = 0; i < MAXLOCK; i++) step(0, 4'b1001, 4'b0001, 4'b0001, 0);
      step(0, 4'b1001, 4'b0001, 4'b1000, 1);
      step(0, 4'b1001, 4'b0001, 4'b0001, 0);
      step(0, 4'b1001, 4'b0000, 4'b0001, 0);
      step(0, 4'b1001, 4'b0000, 4'b1000, 0);
      step(0, 4'b0000, 4'b0000, 4'b0000, 0);

      // Owner 2 drops Req in its 2nd HOLD cycle; 0 wins the cycle after
      step(0, 4'b0100, 4'b0100, 4'b0100, 0);
      step(0, 4'b0110, 4'b0100, 4'b0100, 0);
      step(0, 4'b0011, 4'b0000, 4'b0000, 0);
      step(0, 4'b0011, 4'b0000, 4'b0001, 0);
      step(0, 4'b0011, 4'b0000, 4'b0010, 0);

      // Reset during HOLD: no write that edge, first grant afterwards goes to 0
      step(0, 4'b1111, 4'b0100, 4'b0100, 0);
      step(1, 4'b1111, 4'b0100, 4'b0000, 0);
      step(0, 4'b1111, 4'b0000, 4'b0001, 0);
      step(0, 4'b1111, 4'b0000, 4'b0010, 0);
      step(0, 4'b0000, 4'b0000, 4'b0000, 0);

      // Drain with a bounded wait
      for (int i = 0; i < 20 && (cyc_q.size() > 0 || wr_q.size() > 0); i++) @(posedge clk);
      @(posedge clk);
      if (cyc_q.size() > 0 || wr_q.size() > 0)
         chk("drain_timeout", 32'(cyc_q.size() + wr_q.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sharedreg_arb.md
# sharedreg_arb

Round-robin arbiter and sequencer for one shared enable register. Arbitrates up to NREQ requesters for the register's write enable and steers the winner's data into it. Supports bounded multi-cycle ownership (lock) so a requester can issue back-to-back writes without interleaving. Used wherever several pipeline or CSR-style producers update a single architectural register.

## Interface
- WIDTH, 8, data width of the shared register
- NREQ, 4, number of requesters (≥2)
- MAXLOCK, 8, maximum consecutive grant cycles one locked owner may hold (≥2)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- Req  in  NREQ  per-requester write request
- Lock  in  NREQ  per-requester request to keep ownership after this grant
- WData  in  NREQ*WIDTH  flattened write data; requester i occupies bits [i*WIDTH +: WIDTH]
- Grant  out  NREQ  one-hot (or zero) grant, combinational, same cycle as Req
- GrantIdx  out  $clog2(NREQ)  index of granted requester; 0 when Grant is zero
- Q  out  WIDTH  shared register contents
- QWritten  out  1  registered pulse: Q was written on the preceding edge
- LockTimeout  out  1  registered pulse: a lock was force-released on the preceding edge

## Operation
- Reset state: FSM ARB, priority pointer 0, lock counter 0, owner 0, Q = 0, QWritten = 0, LockTimeout = 0.
- ARB state: winner = first requester with Req set, searching from pointer upward and wrapping modulo NREQ. Grant[winner] = 1 and the register writes WData[winner] at the edge. Pointer then becomes (winner+1) mod NREQ. No Req means Grant = 0, no write, and the pointer holds.
- ARB → HOLD when winner has Lock set. Owner = winner, counter = 1.
- HOLD state: only the owner is eligible. If Req[owner], grant and write, and the counter increments. All other requesters see Grant = 0, even if Req is set.
- HOLD → ARB, with no write that cycle, when Req[owner] = 0.
- HOLD → ARB after the write when Lock[owner] = 0. This is a normal release.
- HOLD → ARB after the write when the counter reaches MAXLOCK. This is a forced release, and LockTimeout pulses next cycle.
- Lock without Req is ignored.
- Pointer is not changed in HOLD. It already points past the owner, so other requesters win first after release.
- After a forced release, the former owner may win again only if no other requester is pending. It may then re-lock, starting a fresh counter.
- Reset asserted mid-HOLD returns to the reset state at that edge. No write occurs in a reset cycle, even if Req is set.

## Timing
- Grant/GrantIdx are combinational from Req, Lock, state, pointer and owner; there is no registered grant latency.
- Q updates on the clock edge ending the grant cycle. QWritten is high exactly the following cycle, once per write.
- Locked owner throughput: one write per cycle, at most MAXLOCK consecutive.
- Worst-case wait for a continuously requesting, non-locking requester: (NREQ−1)·MAXLOCK cycles.
- Grant is one-hot or zero in every cycle, including reset cycles.

## Structure
- Shared package holds:
  - the state typedef (ARB, HOLD);
  - the counter width, $clog2(MAXLOCK+1), derived in-module from the parameter.
- Sub-module rrpick: combinational NREQ-wide round-robin priority picker (Req, pointer → one-hot, index).
- Q is held in the codebase's standard enable flop with synchronous reset (flopenr), enabled by |Grant.
- Pointer, owner, counter and pulse outputs are plain synchronous-reset registers.

## Test plan
- Round-robin fairness: NREQ=4, Req=4'b1111, Lock=0 held 8 cycles → GrantIdx sequence 0,1,2,3,0,1,2,3. Q follows each WData one cycle later, and QWritten stays high from cycle 2.
- Wrap and skip: pointer=3, Req=4'b0101 → grant 0; next cycle grant 2. Req=0 → Grant=0, Q unchanged, QWritten low next cycle.
- Normal lock: requester 1 asserts Req and Lock for 3 cycles, then drops Lock with Req held, while Req[2] is constantly high. Expected: grants 1,1,1,1 (the release cycle still writes), then 2; requester 2 is never granted during HOLD.
- Forced release: MAXLOCK=8, requester 0 holds Req and Lock continuously, Req[3] high. Expected: 8 grants to 0, LockTimeout pulse in cycle 9, grant to 3 in cycle 9, then 0 re-granted and re-locked.
- Owner drops Req mid-HOLD: Req[2] falls in the 2nd HOLD cycle → no write that cycle, FSM is back in ARB, and the next pending requester is granted the following cycle.
- Reset mid-operation: reset asserted during HOLD with Req=4'b1111 → no write that edge. Q=0 and QWritten=0 next cycle, and the first post-reset grant goes to requester 0.
